// File: rtl/snoop_initiator_pkg.sv
// Shared types for the snoop initiator: ACE AC/CR/CD channel structs, snoop codes,
// and the consolidated result record handed back to the coherence interconnect.
package snoop_initiator_pkg;

    localparam int unsigned AcAddrWidth  = 64;
    localparam int unsigned AcSnoopWidth = 4;
    localparam int unsigned AcProtWidth  = 3;
    localparam int unsigned CdDataWidth  = 64;

    typedef enum logic [AcSnoopWidth-1:0] {
        SNOOP_READ_ONCE             = 4'b0000,
        SNOOP_READ_SHARED           = 4'b0001,
        SNOOP_READ_CLEAN            = 4'b0010,
        SNOOP_READ_NOT_SHARED_DIRTY = 4'b0011,
        SNOOP_READ_UNIQUE           = 4'b0111,
        SNOOP_CLEAN_SHARED          = 4'b1000,
        SNOOP_CLEAN_INVALID         = 4'b1001,
        SNOOP_MAKE_INVALID          = 4'b1101
    } snoop_e;

    typedef struct packed {
        logic [AcAddrWidth-1:0]  addr;
        logic [AcSnoopWidth-1:0] snoop;
        logic [AcProtWidth-1:0]  prot;
    } ac_chan_t;

    // Field order follows CRRESP[4:0]: WasUnique, IsShared, PassDirty, Error, DataTransfer.
    typedef struct packed {
        logic wasUnique;
        logic isShared;
        logic passDirty;
        logic error;
        logic dataTransfer;
    } cr_resp_t;

    typedef struct packed {
        logic [CdDataWidth-1:0] data;
        logic                   last;
    } cd_chan_t;

    typedef struct packed {
        logic     ac_valid;
        ac_chan_t ac;
        logic     cr_ready;
        logic     cd_ready;
    } snoop_req_t;

    typedef struct packed {
        logic     ac_ready;
        logic     cr_valid;
        cr_resp_t cr_resp;
        logic     cd_valid;
        cd_chan_t cd;
    } snoop_resp_t;

    typedef struct packed {
        cr_resp_t               cr;
        logic [CdDataWidth-1:0] data;
        logic                   error;
        logic                   timeout;
    } snoop_init_rsp_t;

    // Width of a counter that must hold values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A CR response only announces a CD transfer when it is not also an error.
    function automatic logic cr_expects_data(input cr_resp_t cr);
        return cr.dataTransfer & ~cr.error;
    endfunction

endpackage

// File: rtl/snoop_initiator.sv
// Snoop initiator: issues one ACE snoop on AC, collects CR and any CD beats, and
// returns a single registered result (response bits, line data, error/timeout).
module snoop_initiator
    import snoop_initiator_pkg::*;
#(
    parameter int unsigned NumBeats      = 1,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned AddrWidth     = 64,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    output logic                          busy_o,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [AddrWidth-1:0]          req_addr_i,
    input  logic [AcSnoopWidth-1:0]       req_snoop_i,
    output snoop_req_t                    snoop_req_o,
    input  snoop_resp_t                   snoop_resp_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output cr_resp_t                      rsp_cr_o,
    output logic [NumBeats*DataWidth-1:0] rsp_data_o,
    output logic                          rsp_error_o,
    output logic                          rsp_timeout_o
);

    localparam int unsigned BeatWidth  = cnt_width(NumBeats);
    localparam int unsigned TimerWidth = cnt_width(TimeoutCycles);
    localparam logic [BeatWidth-1:0]  LastBeat   = BeatWidth'(NumBeats - 1);
    localparam logic [TimerWidth-1:0] TimerLimit = TimerWidth'(TimeoutCycles - 1);
    localparam logic                  TimeoutEn  = (TimeoutCycles != 0);

    typedef enum logic [2:0] {
        IDLE,
        SEND_AC,
        WAIT_CR,
        RECV_CD,
        RESPOND
    } state_e;

    state_e                                state_q, state_d;
    logic [AddrWidth-1:0]                  addr_q, addr_d;
    logic [AcSnoopWidth-1:0]               snoop_q, snoop_d;
    cr_resp_t                              cr_q, cr_d;
    logic [NumBeats-1:0][DataWidth-1:0]    data_q, data_d;
    logic                                  error_q, error_d;
    logic                                  timeout_q, timeout_d;
    logic [BeatWidth-1:0]                  beat_q, beat_d;
    logic [TimerWidth-1:0]                 timer_q, timer_d;
    logic                                  at_last_beat;

    assign at_last_beat = (beat_q == LastBeat);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            snoop_q   <= '0;
            cr_q      <= '0;
            data_q    <= '0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
            beat_q    <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            snoop_q   <= snoop_d;
            cr_q      <= cr_d;
            data_q    <= data_d;
            error_q   <= error_d;
            timeout_q <= timeout_d;
            beat_q    <= beat_d;
            timer_q   <= timer_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        snoop_d   = snoop_q;
        cr_d      = cr_q;
        data_d    = data_q;
        error_d   = error_q;
        timeout_d = timeout_q;
        beat_d    = beat_q;
        timer_d   = timer_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d   = SEND_AC;
                    addr_d    = req_addr_i;
                    snoop_d   = req_snoop_i;
                    cr_d      = '0;
                    data_d    = '0;
                    error_d   = 1'b0;
                    timeout_d = 1'b0;
                    beat_d    = '0;
                    timer_d   = '0;
                end
            end

            SEND_AC: begin
                if (snoop_resp_i.ac_ready) begin
                    state_d = WAIT_CR;
                    timer_d = '0;
                end
            end

            // A CR landing on the timeout cycle takes priority over the timeout.
            WAIT_CR: begin
                if (snoop_resp_i.cr_valid) begin
                    cr_d = snoop_resp_i.cr_resp;
                    if (snoop_resp_i.cr_resp.error) begin
                        error_d = 1'b1;
                        state_d = RESPOND;
                    end else if (cr_expects_data(snoop_resp_i.cr_resp)) begin
                        beat_d  = '0;
                        state_d = RECV_CD;
                    end else begin
                        state_d = RESPOND;
                    end
                end else if (TimeoutEn && (timer_q == TimerLimit)) begin
                    error_d   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = RESPOND;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
            end

            // Exit on LAST or on the final slot; the two disagreeing is a protocol error.
            RECV_CD: begin
                if (snoop_resp_i.cd_valid) begin
                    data_d[beat_q] = DataWidth'(snoop_resp_i.cd.data);
                    if (snoop_resp_i.cd.last || at_last_beat) begin
                        state_d = RESPOND;
                        if (snoop_resp_i.cd.last != at_last_beat) begin
                            error_d = 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end

            RESPOND: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        snoop_req_o          = '0;
        snoop_req_o.ac_valid = (state_q == SEND_AC);
        snoop_req_o.ac.addr  = AcAddrWidth'(addr_q);
        snoop_req_o.ac.snoop = snoop_q;
        snoop_req_o.ac.prot  = '0;
        snoop_req_o.cr_ready = (state_q == WAIT_CR);
        snoop_req_o.cd_ready = (state_q == RECV_CD);

        req_ready_o   = (state_q == IDLE);
        busy_o        = (state_q != IDLE);
        rsp_valid_o   = (state_q == RESPOND);
        rsp_cr_o      = cr_q;
        rsp_data_o    = data_q;
        rsp_error_o   = error_q;
        rsp_timeout_o = timeout_q;
    end

endmodule

// File: tb/tb_snoop_initiator.sv
// Bench for snoop_initiator (NumBeats=2, TimeoutCycles=8): table vectors, a reset-in-RECV_CD
// sequence, and randomized snoops checked against a rule-level reference model.
module tb_snoop_initiator;
    import snoop_initiator_pkg::*;

    localparam int NB      = 2;
    localparam int TO      = 8;
    localparam int NEVER   = -1;
    localparam int NO_LAST = 99;
    localparam int NTBL    = 10;
    localparam int NRAND   = 40;

    logic         clk = 1'b0;
    logic         rst;
    logic         busy;
    logic         req_valid;
    logic         req_ready;
    logic [63:0]  req_addr;
    logic [3:0]   req_snoop;
    snoop_req_t   snoop_req;
    snoop_resp_t  snoop_resp;
    logic         rsp_valid;
    logic         rsp_ready;
    cr_resp_t     rsp_cr;
    logic [127:0] rsp_data;
    logic         rsp_error;
    logic         rsp_timeout;

    always #5 clk = ~clk;

    snoop_initiator #(
        .NumBeats(NB),
        .DataWidth(64),
        .AddrWidth(64),
        .TimeoutCycles(TO)
    ) u_dut (
        .clk_i(clk),
        .rst_i(rst),
        .busy_o(busy),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_addr_i(req_addr),
        .req_snoop_i(req_snoop),
        .snoop_req_o(snoop_req),
        .snoop_resp_i(snoop_resp),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_cr_o(rsp_cr),
        .rsp_data_o(rsp_data),
        .rsp_error_o(rsp_error),
        .rsp_timeout_o(rsp_timeout)
    );

    typedef struct {
        logic [63:0]  addr;
        logic [3:0]   snoop;
        int           ac_delay;
        int           cr_delay;
        logic [4:0]   cr;
        int           last_pos;
        int           cd_gap;
        int           rsp_delay;
        logic [63:0]  d0;
        logic [63:0]  d1;
        int           exp_lat;
        logic [4:0]   exp_cr;
        logic [127:0] exp_data;
        logic         exp_err;
        logic         exp_to;
    } vec_t;

    vec_t tbl[NTBL];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [63:0] addr, input logic [3:0] snoop,
                                 input int ac, input int crd, input logic [4:0] cr,
                                 input int lastp, input int gap, input int rspd,
                                 input logic [63:0] d0, input logic [63:0] d1,
                                 input int lat, input logic [4:0] ecr, input logic [127:0] edata,
                                 input logic err, input logic to);
        vec_t v;
        v.addr = addr;   v.snoop = snoop;  v.ac_delay = ac;  v.cr_delay = crd;
        v.cr = cr;       v.last_pos = lastp; v.cd_gap = gap; v.rsp_delay = rspd;
        v.d0 = d0;       v.d1 = d1;
        v.exp_lat = lat; v.exp_cr = ecr;   v.exp_data = edata;
        v.exp_err = err; v.exp_to = to;
        return v;
    endfunction

    // Expected result from the snoop rules: how long each phase lasts and what is kept.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   wait_cycles;
        int   beats;
        logic got_cr;
        logic xfer;
        r = v;
        got_cr      = (v.cr_delay >= 0) && (v.cr_delay <= TO - 1);
        wait_cycles = got_cr ? v.cr_delay : TO - 1;
        xfer        = got_cr && !v.cr[1] && v.cr[0];
        beats       = !xfer ? 0 : (v.last_pos < NB) ? v.last_pos + 1 : NB;
        r.exp_lat   = 3 + v.ac_delay + wait_cycles + beats * (v.cd_gap + 1);
        r.exp_cr    = got_cr ? v.cr : 5'b0;
        r.exp_to    = !got_cr;
        r.exp_err   = !got_cr || v.cr[1] || (xfer && (v.last_pos != NB - 1));
        r.exp_data  = '0;
        if (beats >= 1) r.exp_data[63:0]   = v.d0;
        if (beats >= 2) r.exp_data[127:64] = v.d1;
        return r;
    endfunction

    task automatic checkResult(input string pfx, input vec_t v);
        checkOutput({pfx, "_cr"},      128'(rsp_cr),      128'(v.exp_cr));
        checkOutput({pfx, "_data"},    rsp_data,          v.exp_data);
        checkOutput({pfx, "_error"},   128'(rsp_error),   128'(v.exp_err));
        checkOutput({pfx, "_timeout"}, 128'(rsp_timeout), 128'(v.exp_to));
    endtask

    // Issues one command and plays the snooped cache with the delays carried by the vector.
    task automatic applyStimulus(input string pfx, input vec_t v);
        int   c = 0;
        int   ac_cnt = 0;
        int   cr_cnt = 0;
        int   cd_cnt = 0;
        int   beat = 0;
        int   hold = 0;
        logic done = 1'b0;
        checkOutput({pfx, "_req_ready"}, 128'(req_ready), 128'(1));
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_snoop = v.snoop;
        while (!done && c < 200) begin
            @(posedge clk); #1;
            c++;
            req_valid  = 1'b0;
            req_addr   = {$urandom, $urandom};
            req_snoop  = 4'($urandom);
            snoop_resp = '0;
            rsp_ready  = 1'b0;
            if (snoop_req.ac_valid) begin
                checkOutput({pfx, "_ac_addr"},  128'(snoop_req.ac.addr),  128'(v.addr));
                checkOutput({pfx, "_ac_snoop"}, 128'(snoop_req.ac.snoop), 128'(v.snoop));
                snoop_resp.ac_ready = (ac_cnt >= v.ac_delay);
                ac_cnt++;
            end
            if (snoop_req.cr_ready) begin
                snoop_resp.cr_resp  = cr_resp_t'(v.cr);
                snoop_resp.cr_valid = (v.cr_delay >= 0) && (cr_cnt >= v.cr_delay);
                cr_cnt++;
            end
            if (snoop_req.cd_ready) begin
                if (cd_cnt >= v.cd_gap) begin
                    snoop_resp.cd_valid = 1'b1;
                    snoop_resp.cd.data  = (beat == 0) ? v.d0 : (beat == 1) ? v.d1 : {$urandom, $urandom};
                    snoop_resp.cd.last  = (beat == v.last_pos);
                    beat++;
                    cd_cnt = 0;
                end else begin
                    cd_cnt++;
                end
            end
            if (rsp_valid) begin
                if (hold == 0) begin
                    checkOutput({pfx, "_latency"}, 128'(c), 128'(v.exp_lat));
                end else begin
                    checkOutput({pfx, "_hold_req_ready"}, 128'(req_ready), 128'(0));
                end
                checkResult(pfx, v);
                if (hold >= v.rsp_delay) begin
                    rsp_ready = 1'b1;
                    done = 1'b1;
                end
                hold++;
            end
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("[TB] FAIL %s_rsp_bound: no response within 200 cycles, expected one at %0d", pfx, v.exp_lat);
        end
        @(posedge clk); #1;
        rsp_ready  = 1'b0;
        snoop_resp = '0;
        checkOutput({pfx, "_idle_after"}, 128'(busy), 128'(0));
    endtask

    task automatic checkResetOutputs(input string pfx);
        checkOutput({pfx, "_req_ready"}, 128'(req_ready),   128'(1));
        checkOutput({pfx, "_busy"},      128'(busy),        128'(0));
        checkOutput({pfx, "_snoop_req"}, 128'(snoop_req),   128'(0));
        checkOutput({pfx, "_rsp_valid"}, 128'(rsp_valid),   128'(0));
        checkOutput({pfx, "_rsp_cr"},    128'(rsp_cr),      128'(0));
        checkOutput({pfx, "_rsp_data"},  rsp_data,          128'(0));
        checkOutput({pfx, "_error"},     128'(rsp_error),   128'(0));
        checkOutput({pfx, "_timeout"},   128'(rsp_timeout), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        int   r;
        tbl[0] = mkv(64'h8000_1008, SNOOP_READ_SHARED, 0, 0, 5'b01001, 1, 0, 0,
                     64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF,
                     5, 5'b01001, {64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_0000_0001}, 1'b0, 1'b0);
        tbl[1] = mkv(64'h8000_1008, SNOOP_READ_SHARED, 0, 0, 5'b01001, 0, 0, 0,
                     64'hDEAD_BEEF_0000_0001, 64'h5555_5555_5555_5555,
                     4, 5'b01001, {64'h0, 64'hDEAD_BEEF_0000_0001}, 1'b1, 1'b0);
        tbl[2] = mkv(64'h4000_0040, SNOOP_CLEAN_INVALID, 0, 0, 5'b00000, 0, 0, 0,
                     64'h1111, 64'h2222, 3, 5'b00000, 128'h0, 1'b0, 1'b0);
        tbl[3] = mkv(64'h0000_0ABC_0000_0100, SNOOP_READ_UNIQUE, 5, 0, 5'b00010, 0, 0, 0,
                     64'h3333, 64'h4444, 8, 5'b00010, 128'h0, 1'b1, 1'b0);
        tbl[4] = mkv(64'h0000_0000_1234_5600, SNOOP_CLEAN_SHARED, 0, NEVER, 5'b01001, 1, 0, 2,
                     64'h5555, 64'h6666, 10, 5'b00000, 128'h0, 1'b1, 1'b1);
        tbl[5] = mkv(64'h0000_0000_0000_0040, SNOOP_MAKE_INVALID, 0, 7, 5'b00100, 0, 0, 0,
                     64'h7777, 64'h8888, 10, 5'b00100, 128'h0, 1'b0, 1'b0);
        tbl[6] = mkv(64'hFFFF_FFFF_FFFF_FFC0, SNOOP_READ_ONCE, 0, 6, 5'b00001, NO_LAST, 0, 0,
                     64'hAAAA_0000_BBBB_0000, 64'hCCCC_0000_DDDD_0000,
                     11, 5'b00001, {64'hCCCC_0000_DDDD_0000, 64'hAAAA_0000_BBBB_0000}, 1'b1, 1'b0);
        tbl[7] = mkv(64'h0000_0000_2000_0080, SNOOP_READ_CLEAN, 1, 2, 5'b10000, 0, 0, 3,
                     64'h9999, 64'hAAAA, 6, 5'b10000, 128'h0, 1'b0, 1'b0);
        tbl[8] = mkv(64'h0000_0000_3000_00C0, SNOOP_READ_SHARED, 0, 0, 5'b00011, 1, 0, 0,
                     64'hBBBB, 64'hCCCC, 3, 5'b00011, 128'h0, 1'b1, 1'b0);
        tbl[9] = mkv(64'h0000_0000_4000_0100, SNOOP_READ_NOT_SHARED_DIRTY, 0, 0, 5'b00101, 1, 2, 1,
                     64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0,
                     9, 5'b00101, {64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F}, 1'b0, 1'b0);

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_snoop  = '0;
        snoop_resp = '0;
        rsp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkResetOutputs("reset");

        for (int i = 0; i < NTBL; i++) begin
            applyStimulus($sformatf("tbl%0d", i), tbl[i]);
        end

        // Reset while collecting CD must abandon the snoop without a response.
        req_valid = 1'b1;
        req_addr  = 64'h8000_2000;
        req_snoop = SNOOP_READ_SHARED;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checkOutput("rstseq_ac_valid", 128'(snoop_req.ac_valid), 128'(1));
        snoop_resp.ac_ready = 1'b1;
        @(posedge clk); #1;
        snoop_resp = '0;
        checkOutput("rstseq_cr_ready", 128'(snoop_req.cr_ready), 128'(1));
        snoop_resp.cr_valid = 1'b1;
        snoop_resp.cr_resp  = cr_resp_t'(5'b01001);
        @(posedge clk); #1;
        snoop_resp = '0;
        checkOutput("rstseq_cd_ready", 128'(snoop_req.cd_ready), 128'(1));
        snoop_resp.cd_valid  = 1'b1;
        snoop_resp.cd.data   = 64'hCAFE_F00D_0000_0001;
        snoop_resp.cd.last   = 1'b0;
        @(posedge clk); #1;
        snoop_resp = '0;
        checkOutput("rstseq_still_cd", 128'(snoop_req.cd_ready), 128'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkResetOutputs("midrst");

        for (int i = 0; i < NRAND; i++) begin
            v.addr      = {$urandom, $urandom};
            v.snoop     = 4'($urandom);
            v.ac_delay  = int'($urandom_range(0, 3));
            r           = int'($urandom_range(0, 10));
            v.cr_delay  = (r == 10) ? NEVER : r;
            v.cr        = 5'($urandom);
            r           = int'($urandom_range(0, 2));
            v.last_pos  = (r == 2) ? NO_LAST : r;
            v.cd_gap    = int'($urandom_range(0, 2));
            v.rsp_delay = int'($urandom_range(0, 2));
            v.d0        = {$urandom, $urandom};
            v.d1        = {$urandom, $urandom};
            v = model(v);
            applyStimulus($sformatf("rand%0d", i), v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
